// File: rtl/sudoku_pkg.sv
// Shared definitions for the game session controller: state encoding,
// default session constants and datapath widths.
package sudoku_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_SCORING = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  localparam int DEF_TIME_LIMIT = 1800;
  localparam int DEF_GRACE      = 60;
  localparam int DEF_MAX_SCORE  = 100;

  localparam int TIMER_W   = 12;
  localparam int SCORE_W   = 8;
  localparam int PROD_W    = 18;
  localparam int DIV_W     = 11;
  localparam int DIV_STEPS = 18;

endpackage

// File: rtl/score_divider.sv
// Sequential restoring divider: one quotient bit per clock, done pulses
// DIV_STEPS cycles after go is sampled.
module score_divider
  import sudoku_pkg::*;
(
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              go,
  input  logic [PROD_W-1:0] dividend,
  input  logic [DIV_W-1:0]  divisor,
  output logic [PROD_W-1:0] quotient,
  output logic              done
);

  logic [PROD_W-1:0] quo_q;
  logic [DIV_W-1:0]  rem_q;
  logic [4:0]        cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [DIV_W:0]    shifted_d;

  // Partial remainder with the next dividend bit shifted in.
  always_comb begin
    shifted_d = {rem_q, quo_q[PROD_W-1]};
  end

  // Load on go, then one restoring step per cycle; the dividend register
  // is reused to collect quotient bits as it shifts out.
  always_ff @(posedge clk_50MHz) begin
    done_q <= 1'b0;
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (go) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (shifted_d >= {1'b0, divisor}) begin
        rem_q <= DIV_W'(shifted_d - {1'b0, divisor});
        quo_q <= {quo_q[PROD_W-2:0], 1'b1};
      end else begin
        rem_q <= shifted_d[DIV_W-1:0];
        quo_q <= {quo_q[PROD_W-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'(DIV_STEPS - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Game session controller: timed session with pause, player finish and
// timeout, followed by a time-decaying score computed by a serial divider.
module game_session_ctrl
  import sudoku_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIME_LIMIT = DEF_TIME_LIMIT,
  parameter int GRACE      = DEF_GRACE,
  parameter int MAX_SCORE  = DEF_MAX_SCORE
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               finish,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] timer,
  output logic               tick_1hz,
  output logic [SCORE_W-1:0] score,
  output logic               score_valid,
  output logic               time_up
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(TIME_LIMIT - GRACE);

  state_e             state_q;
  logic [PW-1:0]      presc_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] snap_q;
  logic [SCORE_W-1:0] score_q;
  logic               score_valid_q;
  logic               time_up_q;
  logic               div_go_q;

  logic               restart_d;
  logic               tick_d;
  logic [TIMER_W-1:0] elapsed_d;
  logic [PROD_W-1:0]  dividend_d;
  logic [PROD_W-1:0]  div_quotient;
  logic               div_done;

  // Start is honoured only when no session is in progress.
  assign restart_d = start && (state_q == ST_IDLE || state_q == ST_DONE ||
                               state_q == ST_TIMEOUT);

  // A second is counted only while running; a paused prescaler at its
  // terminal value must not show a tick.
  assign tick_d = (state_q == ST_RUNNING) && (presc_q == PW'(CLK_HZ - 1));

  // Seconds past the grace window, scaled by the full score.
  always_comb begin
    if (snap_q <= TIMER_W'(GRACE)) begin
      elapsed_d = '0;
    end else begin
      elapsed_d = snap_q - TIMER_W'(GRACE);
    end
    dividend_d = PROD_W'(elapsed_d) * PROD_W'(MAX_SCORE);
  end

  score_divider u_div (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .go        (div_go_q),
    .dividend  (dividend_d),
    .divisor   (DIVISOR),
    .quotient  (div_quotient),
    .done      (div_done)
  );

  // Session FSM with prescaler, timer, snapshot and score registers.
  always_ff @(posedge clk_50MHz) begin
    div_go_q <= 1'b0;
    if (reset) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      timer_q       <= '0;
      snap_q        <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      time_up_q     <= 1'b0;
    end else if (restart_d) begin
      state_q       <= ST_RUNNING;
      presc_q       <= '0;
      timer_q       <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      time_up_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RUNNING: begin
          if (finish) begin
            // Finish wins: this cycle's tick is not counted.
            snap_q   <= timer_q;
            state_q  <= ST_SCORING;
            div_go_q <= 1'b1;
          end else if (tick_d) begin
            // A tick coinciding with pause still completes its second.
            presc_q <= '0;
            if (timer_q != TIMER_W'(TIME_LIMIT)) begin
              timer_q <= timer_q + TIMER_W'(1);
            end
            if (timer_q == TIMER_W'(TIME_LIMIT - 1)) begin
              state_q       <= ST_TIMEOUT;
              time_up_q     <= 1'b1;
              score_q       <= '0;
              score_valid_q <= 1'b1;
            end else if (pause) begin
              state_q <= ST_PAUSED;
            end
          end else if (pause) begin
            // The pause cycle itself does not advance the prescaler.
            state_q <= ST_PAUSED;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (finish) begin
            snap_q   <= timer_q;
            state_q  <= ST_SCORING;
            div_go_q <= 1'b1;
          end else if (pause) begin
            state_q <= ST_RUNNING;
          end
        end
        ST_SCORING: begin
          if (div_done) begin
            score_q       <= SCORE_W'(PROD_W'(MAX_SCORE) - div_quotient);
            score_valid_q <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign timer       = timer_q;
  assign tick_1hz    = tick_d;
  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign time_up     = time_up_q;

endmodule

// File: doc/game_session_ctrl.md
GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock cycles per game second.
REQ-002 SHALL have parameter TIME_LIMIT, default 1800, session length in seconds.
REQ-003 SHALL have parameter GRACE, default 60, seconds that earn full score.
REQ-004 SHALL have parameter MAX_SCORE, default 100, score awarded within GRACE.
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high:
- clk_50MHz  in  1   system clock, all logic on its rising edge
- reset  in  1   synchronous active-high reset
- start  in  1   one-cycle pulse; begin or restart a session
- pause  in  1   one-cycle pulse; toggle RUNNING/PAUSED
- finish  in  1   level; player ends game (sampled each cycle)
- state  out  3   current FSM state code
- timer  out  12  elapsed seconds
- tick_1hz  out  1   one-cycle pulse per counted second
- score  out  8   final score
- score_valid  out  1   score is final
- time_up  out  1   session expired

Function
REQ-006 SHALL implement states IDLE=0, RUNNING=1, PAUSED=2, SCORING=3, DONE=4, TIMEOUT=5, with state driven directly from the state register.
REQ-007 SHALL transition IDLE->RUNNING on start, clearing prescaler, timer, score, score_valid and time_up in that same edge.
REQ-008 SHALL restart identically (clear, ->RUNNING) on start in DONE or TIMEOUT, and SHALL ignore start in RUNNING, PAUSED and SCORING.
REQ-009 SHALL run a prescaler 0..CLK_HZ-1 only in RUNNING; tick_1hz SHALL be 1 for the cycle where the prescaler equals CLK_HZ-1, after which it wraps to 0.
REQ-010 SHALL hold the prescaler value in PAUSED and resume from it on return to RUNNING, so no fractional second is lost or gained.
REQ-011 SHALL increment timer by 1 on the edge following each tick_1hz, saturating at TIME_LIMIT.
REQ-012 SHALL toggle RUNNING<->PAUSED on pause, and SHALL ignore pause in all other states.
REQ-013 SHALL leave RUNNING or PAUSED for SCORING when finish=1, latching timer into a snapshot register.
REQ-014 SHALL give finish priority over tick_1hz and pause in the same cycle: the snapshot excludes that tick, and timer does not increment.
REQ-015 SHALL go RUNNING->TIMEOUT on the edge where timer becomes TIME_LIMIT (unless finish takes priority); TIMEOUT sets time_up=1, score=0, score_valid=1.
REQ-016 SHALL, in SCORING, compute elapsed = (snapshot<=GRACE) ? 0 : snapshot-GRACE, and then score = MAX_SCORE - (elapsed*MAX_SCORE)/(TIME_LIMIT-GRACE), truncating toward zero.
REQ-017 SHALL size the product at 18 bits and the divisor at 11 bits, with no overflow for defaults.
REQ-018 SHALL perform the division with a sequential restoring divider, 1 quotient bit per cycle and no combinational divide operator.
REQ-019 SHALL raise score_valid and enter DONE exactly 20 clock edges after the edge that sampled finish=1.
REQ-020 SHALL keep score and score_valid stable in DONE and TIMEOUT until start or reset.
REQ-021 SHALL ignore finish in IDLE, SCORING, DONE and TIMEOUT.

Reset
REQ-022 SHALL on reset force state=IDLE, timer=0, prescaler=0, score=0, score_valid=0, time_up=0, tick_1hz=0.
REQ-023 SHALL abort any in-progress division on reset mid-SCORING, with no score_valid pulse afterwards.
REQ-024 SHALL give reset priority over start, pause and finish.

Structure
REQ-025 SHALL place the state encoding and default constants (TIME_LIMIT, GRACE, MAX_SCORE) in shared package sudoku_pkg.
REQ-026 SHALL implement the divider as sub-module score_divider (ports: clk_50MHz, reset, go, dividend[17:0], divisor[10:0], quotient[17:0], done), with done pulsed 18 cycles after go.

Verification
REQ-027 SHALL check, with CLK_HZ=4: start, then 10 s, then finish -> timer=10, score=100 (elapsed 0), score_valid 20 edges after finish.
REQ-028 SHALL check, with CLK_HZ=4: start, finish at timer=930 -> score=50, and at timer=61 -> score=100 (100-100/1740=100).
REQ-029 SHALL check, with CLK_HZ=4: start, run to 1800 s -> TIMEOUT, time_up=1, score=0, timer held at 1800.
REQ-030 SHALL check: pause at prescaler=2 for 50 cycles, then resume -> next tick_1hz exactly 2 cycles later, with timer unchanged during the pause.
REQ-031 SHALL check: finish asserted in the same cycle as tick_1hz at timer=99 -> snapshot=99, score=MAX_SCORE-(39*100)/1740=98.
REQ-032 SHALL check: reset 5 cycles into SCORING -> IDLE, all outputs 0, with no score_valid for 30 cycles.
